dcache_l2_responder: RTL and testbench

//  L2-side responder for the Dcache line interface. Captures single-cycle line-fill requests and

---
 rtl/l2_resp_pkg.sv | 12 +
 rtl/l2_req_slot.sv | 30 +++
 rtl/dcache_l2_responder.sv | 130 +++++++++++++
 tb/tb_dcache_l2_responder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_resp_pkg.sv
// Shared types and width helpers for the L2-side Dcache line responder.
package l2_resp_pkg;
  typedef enum logic [1:0] {IDLE, WB, RD, RESP} state_t;

  function automatic int calc_offset_w(input int dw, input int bs);
    return $clog2(dw * bs / 8);
  endfunction

  function automatic int calc_beat_w(input int bs);
    return $clog2(bs);
  endfunction
endpackage

// File: rtl/l2_req_slot.sv
// One-entry request capture register: loads on a pulse, frees when its operation completes.
module l2_req_slot #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic         free,
  input  logic [W-1:0] din,
  output logic         full,
  output logic [W-1:0] q,
  output logic         overrun
);
  always_ff @(posedge CLK) begin
    if (RST) begin
      full    <= 1'b0;
      q       <= '0;
      overrun <= 1'b0;
    end else begin
      // a slot freeing on this edge can take the new pulse
      overrun <= load && full && !free;
      if (load && (!full || free)) begin
        full <= 1'b1;
        q    <= din;
      end else if (free) begin
        full <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/dcache_l2_responder.sv
// Serialises L1 line fills and writebacks into word beats and reassembles fill data into a line.
module dcache_l2_responder
  import l2_resp_pkg::*;
#(
  parameter int data_width    = 32,
  parameter int address_width = 32,
  parameter int block_size    = 32,
  localparam int offset_width = calc_offset_w(data_width, block_size),
  localparam int cache_width  = data_width * block_size,
  localparam int line_aw      = address_width - offset_width,
  localparam int beat_w       = calc_beat_w(block_size)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ADDR_FROM_L1_VALID,
  input  logic [line_aw-1:0]       ADDR_FROM_L1,
  output logic [cache_width-1:0]   DATA_TO_L1,
  output logic                     DATA_TO_L1_VALID,
  input  logic                     WB_VALID,
  input  logic [line_aw-1:0]       WB_ADDR,
  input  logic [cache_width-1:0]   WB_DATA,
  output logic                     WB_DONE,
  output logic                     OVERRUN,
  output logic                     MEM_VALID,
  output logic                     MEM_WE,
  output logic [address_width-1:0] MEM_ADDR,
  output logic [data_width-1:0]    MEM_WDATA,
  input  logic                     MEM_READY,
  input  logic [data_width-1:0]    MEM_RDATA,
  input  logic                     MEM_RVALID
);
  localparam int byte_w = offset_width - beat_w;
  localparam logic [beat_w:0] LAST = (beat_w+1)'(block_size - 1);

  typedef struct packed {
    logic [line_aw-1:0]     addr;
    logic [cache_width-1:0] data;
  } wb_req_t;

  state_t                 state;
  logic [beat_w:0]        beat;
  logic [beat_w-1:0]      rsp;
  logic [cache_width-1:0] asm_q, asm_nxt;
  logic                   fill_full, fill_ovr, wb_full, wb_ovr;
  logic [line_aw-1:0]     fill_addr, line_sel;
  wb_req_t                wb_q;
  logic                   mem_vld, mem_acc, wb_free, fill_free;

  assign mem_acc   = mem_vld && MEM_READY;
  assign wb_free   = (state == WB) && mem_acc && (beat == LAST);
  assign fill_free = (state == RESP);
  assign OVERRUN   = fill_ovr | wb_ovr;

  l2_req_slot #(.W(line_aw)) u_fill (
    .CLK(CLK), .RST(RST), .load(ADDR_FROM_L1_VALID), .free(fill_free),
    .din(ADDR_FROM_L1), .full(fill_full), .q(fill_addr), .overrun(fill_ovr)
  );

  l2_req_slot #(.W($bits(wb_req_t))) u_wb (
    .CLK(CLK), .RST(RST), .load(WB_VALID), .free(wb_free),
    .din({WB_ADDR, WB_DATA}), .full(wb_full), .q(wb_q), .overrun(wb_ovr)
  );

  // read issue stops once the beat counter reaches block_size (top bit set)
  always_comb begin
    mem_vld   = (state == WB) || ((state == RD) && !beat[beat_w]);
    line_sel  = (state == WB) ? wb_q.addr : fill_addr;
    MEM_VALID = mem_vld;
    MEM_WE    = (state == WB);
    MEM_ADDR  = '0;
    MEM_WDATA = '0;
    if (mem_vld)
      MEM_ADDR = {line_sel, {offset_width{1'b0}}}
               | (address_width'(beat[beat_w-1:0]) << byte_w);
    if (state == WB)
      MEM_WDATA = wb_q.data[beat[beat_w-1:0]*data_width +: data_width];
    asm_nxt = asm_q;
    if ((state == RD) && MEM_RVALID)
      asm_nxt[rsp*data_width +: data_width] = MEM_RDATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= IDLE;
      beat             <= '0;
      rsp              <= '0;
      asm_q            <= '0;
      DATA_TO_L1       <= '0;
      DATA_TO_L1_VALID <= 1'b0;
      WB_DONE          <= 1'b0;
    end else begin
      DATA_TO_L1_VALID <= 1'b0;
      WB_DONE          <= 1'b0;
      case (state)
        IDLE: begin
          if (wb_full)        state <= WB;
          else if (fill_full) state <= RD;
        end
        WB: begin
          if (mem_acc) begin
            if (beat == LAST) begin
              beat    <= '0;
              WB_DONE <= 1'b1;
              state   <= IDLE;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        RD: begin
          if (mem_acc) beat <= beat + 1'b1;
          asm_q <= asm_nxt;
          if (MEM_RVALID) begin
            if (rsp == LAST[beat_w-1:0]) begin
              rsp              <= '0;
              beat             <= '0;
              DATA_TO_L1       <= asm_nxt;
              DATA_TO_L1_VALID <= 1'b1;
              state            <= RESP;
            end else begin
              rsp <= rsp + 1'b1;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_l2_responder.sv
// Self-checking bench: memory model on the beat port, line-level reference memory for fills.
module tb_dcache_l2_responder;
  localparam int DW = 32, AW = 32, BS = 32, OW = 7, CW = DW * BS, LAW = AW - OW;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           ADDR_FROM_L1_VALID = 1'b0;
  logic [LAW-1:0] ADDR_FROM_L1 = '0;
  logic [CW-1:0]  DATA_TO_L1;
  logic           DATA_TO_L1_VALID;
  logic           WB_VALID = 1'b0;
  logic [LAW-1:0] WB_ADDR = '0;
  logic [CW-1:0]  WB_DATA = '0;
  logic           WB_DONE, OVERRUN, MEM_VALID, MEM_WE;
  logic [AW-1:0]  MEM_ADDR;
  logic [DW-1:0]  MEM_WDATA;
  logic           MEM_READY = 1'b0;
  logic [DW-1:0]  MEM_RDATA = '0;
  logic           MEM_RVALID = 1'b0;

  always #5 CLK = ~CLK;

  dcache_l2_responder dut (
    .CLK(CLK), .RST(RST),
    .ADDR_FROM_L1_VALID(ADDR_FROM_L1_VALID), .ADDR_FROM_L1(ADDR_FROM_L1),
    .DATA_TO_L1(DATA_TO_L1), .DATA_TO_L1_VALID(DATA_TO_L1_VALID),
    .WB_VALID(WB_VALID), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA), .WB_DONE(WB_DONE),
    .OVERRUN(OVERRUN), .MEM_VALID(MEM_VALID), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_READY(MEM_READY), .MEM_RDATA(MEM_RDATA),
    .MEM_RVALID(MEM_RVALID)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    n_chk++;
    $display("FAIL %s: bound expired or unexpected event", nm);
  endtask

  task automatic chk_line(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    int bad;
    bad = -1;
    for (int k = BS - 1; k >= 0; k--)
      if (act[k*DW +: DW] !== exp[k*DW +: DW]) bad = k;
    n_chk++;
    if (bad < 0) n_pass++;
    else $display("FAIL %s: word %0d got 0x%0h expected 0x%0h", nm, bad,
                  act[bad*DW +: DW], exp[bad*DW +: DW]);
  endtask

  // environment: beat-port memory, output event counters
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t           exp_wr[$];
  logic [DW-1:0] memarr [logic [AW-1:0]];
  logic [DW-1:0] refmem [logic [AW-1:0]];
  int            cyc = 0, n_dv = 0, n_wbd = 0, n_ovr = 0, rd_acc = 0, rd_early = 0, dv_cyc = 0;
  logic [CW-1:0] dv_line = '0;
  int            ready_mode = 0;
  logic          pend_v = 1'b0, stall_v = 1'b0;
  logic [DW-1:0] pend_d = '0, stall_d = '0;
  logic [AW-1:0] stall_a = '0;

  always @(negedge CLK) begin
    wr_t w;
    cyc++;
    if (DATA_TO_L1_VALID) begin n_dv++; dv_cyc = cyc; dv_line = DATA_TO_L1; end
    if (WB_DONE) n_wbd++;
    if (OVERRUN) n_ovr++;
    if (RST) begin
      pend_v = 1'b0; stall_v = 1'b0; MEM_RVALID = 1'b0; MEM_READY = 1'b0;
    end else begin
      MEM_RVALID = pend_v;
      MEM_RDATA  = pend_v ? pend_d : '0;
      pend_v     = 1'b0;
      if (stall_v && MEM_VALID) begin
        chk("stall_addr", MEM_ADDR, stall_a);
        chk("stall_wdata", MEM_WDATA, stall_d);
      end
      stall_v = 1'b0;
      case (ready_mode)
        0:       MEM_READY = 1'b1;
        1:       MEM_READY = (cyc % 3 == 0);
        default: MEM_READY = 1'($urandom_range(0, 1));
      endcase
      if (MEM_VALID && MEM_READY) begin
        if (MEM_WE) begin
          memarr[MEM_ADDR] = MEM_WDATA;
          if (exp_wr.size() == 0) fail("unexpected_write");
          else begin
            w = exp_wr.pop_front();
            chk("wr_addr", MEM_ADDR, w.a);
            chk("wr_data", MEM_WDATA, w.d);
          end
        end else begin
          if (exp_wr.size() != 0) rd_early++;
          rd_acc++;
          pend_v = 1'b1;
          pend_d = memarr.exists(MEM_ADDR) ? memarr[MEM_ADDR] : MEM_ADDR;
        end
      end else if (MEM_VALID) begin
        stall_v = 1'b1; stall_a = MEM_ADDR; stall_d = MEM_WDATA;
      end
    end
  end

  // reference: byte address of word k of a line, and the line as L1 should see it
  function automatic logic [AW-1:0] waddr(input logic [LAW-1:0] l, input int k);
    return AW'(l) * (BS * DW / 8) + AW'(k * (DW / 8));
  endfunction

  function automatic logic [CW-1:0] ref_line(input logic [LAW-1:0] l);
    logic [CW-1:0] r;
    logic [AW-1:0] a;
    for (int k = 0; k < BS; k++) begin
      a = waddr(l, k);
      r[k*DW +: DW] = refmem.exists(a) ? refmem[a] : a;
    end
    return r;
  endfunction

  int c0 = 0;

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic set_fill(input logic [LAW-1:0] l);
    ADDR_FROM_L1 = l; ADDR_FROM_L1_VALID = 1'b1; c0 = cyc + 1;
  endtask

  task automatic set_wb(input logic [LAW-1:0] l, input logic [CW-1:0] d);
    WB_ADDR = l; WB_DATA = d; WB_VALID = 1'b1;
    for (int k = 0; k < BS; k++) begin
      exp_wr.push_back('{a: waddr(l, k), d: d[k*DW +: DW]});
      refmem[waddr(l, k)] = d[k*DW +: DW];
    end
  endtask

  task automatic clr_pulses();
    step(); ADDR_FROM_L1_VALID = 1'b0; WB_VALID = 1'b0;
  endtask

  task automatic wait_dv(input int tgt, input string nm);
    int t;
    t = 0;
    while (n_dv < tgt && t < 3000) begin step(); t++; end
    if (n_dv < tgt) fail(nm);
  endtask

  task automatic wait_wbd(input int tgt, input string nm);
    int t;
    t = 0;
    while (n_wbd < tgt && t < 3000) begin step(); t++; end
    if (n_wbd < tgt) fail(nm);
  endtask

  function automatic logic [CW-1:0] rnd_line();
    logic [CW-1:0] r;
    for (int k = 0; k < BS; k++) r[k*DW +: DW] = $urandom;
    return r;
  endfunction

  typedef struct { logic [LAW-1:0] line; logic [DW-1:0] w0, wl; int lat; } vec_t;
  vec_t tbl[4];

  initial begin
    int b_dv, b_wbd, b_ovr, t;
    logic [CW-1:0] d;
    logic [LAW-1:0] l;

    tbl[0] = '{line: 25'h000123,  w0: 32'h0000_9180, wl: 32'h0000_91FC, lat: 35};
    tbl[1] = '{line: 25'h0,       w0: 32'h0000_0000, wl: 32'h0000_007C, lat: 35};
    tbl[2] = '{line: 25'h1FFFFFF, w0: 32'hFFFF_FF80, wl: 32'hFFFF_FFFC, lat: 35};
    tbl[3] = '{line: 25'h10,      w0: 32'h0000_0800, wl: 32'h0000_087C, lat: 35};

    step(); step();
    chk("rst_mem_valid", MEM_VALID, 0);
    chk("rst_mem_we", MEM_WE, 0);
    chk("rst_mem_addr", MEM_ADDR, 0);
    chk("rst_dv", DATA_TO_L1_VALID, 0);
    chk("rst_wb_done", WB_DONE, 0);
    chk("rst_overrun", OVERRUN, 0);
    chk_line("rst_data", DATA_TO_L1, '0);
    RST = 1'b0;
    step();

    // directed fills of untouched lines: word k reads back its byte address
    foreach (tbl[i]) begin
      b_dv = n_dv;
      set_fill(tbl[i].line); clr_pulses();
      wait_dv(b_dv + 1, "fill_timeout");
      chk("fill_latency", dv_cyc - c0, tbl[i].lat);
      chk("fill_w0", dv_line[0 +: DW], tbl[i].w0);
      chk("fill_wlast", dv_line[(BS-1)*DW +: DW], tbl[i].wl);
      chk_line("fill_line", dv_line, ref_line(tbl[i].line));
      repeat (4) step();
      chk("fill_one_pulse", n_dv, b_dv + 1);
      chk_line("fill_hold", DATA_TO_L1, dv_line);
    end

    // writeback of k=k then fill of the same line one cycle later
    b_dv = n_dv; b_wbd = n_wbd;
    for (int k = 0; k < BS; k++) d[k*DW +: DW] = DW'(k);
    set_wb(25'h10, d); clr_pulses();
    set_fill(25'h10); clr_pulses();
    wait_dv(b_dv + 1, "wbfill_timeout");
    chk_line("wbfill_line", dv_line, ref_line(25'h10));
    chk("wbfill_w5", dv_line[5*DW +: DW], 5);
    chk("wbfill_writes_done", exp_wr.size(), 0);
    chk("wbfill_wb_done", n_wbd, b_wbd + 1);
    chk("wbfill_order", rd_early, 0);

    // writeback under 1-of-3 ready
    ready_mode = 1; b_wbd = n_wbd;
    set_wb(25'h20, rnd_line()); clr_pulses();
    wait_wbd(b_wbd + 1, "stall_wb_timeout");
    repeat (10) step();
    chk("stall_wb_done_once", n_wbd, b_wbd + 1);
    chk("stall_writes_done", exp_wr.size(), 0);
    ready_mode = 0;

    // second fill while the first is in flight is dropped
    b_dv = n_dv; b_ovr = n_ovr;
    set_fill(25'h30); clr_pulses();
    repeat (4) step();
    set_fill(25'h31); clr_pulses();
    wait_dv(b_dv + 1, "ovr_timeout");
    repeat (60) step();
    chk("ovr_pulse", n_ovr, b_ovr + 1);
    chk("ovr_single_fill", n_dv, b_dv + 1);
    chk_line("ovr_line", dv_line, ref_line(25'h30));

    // reset in the middle of a fill
    b_dv = n_dv; t = rd_acc;
    set_fill(25'h40); clr_pulses();
    for (int i = 0; i < 100 && rd_acc < t + 10; i++) step();
    if (rd_acc < t + 10) fail("rst_mid_timeout");
    RST = 1'b1; step();
    chk("rstmid_mem_valid", MEM_VALID, 0);
    chk("rstmid_dv", DATA_TO_L1_VALID, 0);
    chk("rstmid_mem_addr", MEM_ADDR, 0);
    chk_line("rstmid_data", DATA_TO_L1, '0);
    RST = 1'b0;
    repeat (60) step();
    chk("rstmid_no_pulse", n_dv, b_dv);
    set_fill(25'h41); clr_pulses();
    wait_dv(b_dv + 1, "rst_refill_timeout");
    chk("rst_refill_latency", dv_cyc - c0, 35);
    chk_line("rst_refill_line", dv_line, ref_line(25'h41));

    // simultaneous fill and writeback of one line
    b_dv = n_dv; b_wbd = n_wbd;
    set_fill(25'h50); set_wb(25'h50, rnd_line()); clr_pulses();
    wait_dv(b_dv + 1, "both_timeout");
    chk_line("both_line", dv_line, ref_line(25'h50));
    repeat (60) step();
    chk("both_dv_once", n_dv, b_dv + 1);
    chk("both_wb_once", n_wbd, b_wbd + 1);
    chk("both_order", rd_early, 0);

    // random ops with random ready
    ready_mode = 2;
    for (int i = 0; i < 16; i++) begin
      l = 25'h60 + LAW'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        b_wbd = n_wbd;
        set_wb(l, rnd_line()); clr_pulses();
        wait_wbd(b_wbd + 1, "rnd_wb_timeout");
      end else begin
        b_dv = n_dv;
        set_fill(l); clr_pulses();
        wait_dv(b_dv + 1, "rnd_fill_timeout");
        chk_line("rnd_fill_line", dv_line, ref_line(l));
      end
    end
    repeat (5) step();
    chk("rnd_writes_done", exp_wr.size(), 0);
    chk("rnd_order", rd_early, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
